// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - EX/MEM/WB destination scoreboard driving forwarding, load-use stall and redirect flush
// Define HAZARD_FWD_EN to build EX-operand forwarding; without it every dependency stalls until it retires.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_regwen,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   output logic             stall_if,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_d,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwen;
      logic       is_load;
   } sb_entry_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   sb_entry_t sb_id, sb_ex, sb_mem, sb_wb;
   state_t    state_q, state_d;
   logic      ex_rs1, ex_rs2, mem_rs1, mem_rs2;
   logic      hazard;

   function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs, input logic use_rs);
      return e.valid && e.regwen && (e.rd == rs) && (e.rd != 5'd0) && use_rs;
   endfunction

   assign ex_rs1  = sb_match(sb_ex,  id_rs1, id_use_rs1);
   assign ex_rs2  = sb_match(sb_ex,  id_rs2, id_use_rs2);
   assign mem_rs1 = sb_match(sb_mem, id_rs1, id_use_rs1);
   assign mem_rs2 = sb_match(sb_mem, id_rs2, id_use_rs2);

   // Empty slots are stored all-zero so no stale rd/is_load survives a bubble
   always_comb begin
      sb_id = '0;
      if (id_valid && !flush_ex) begin
         sb_id = {1'b1, id_rd, id_regwen, id_is_load};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_ex  <= '0;
         sb_mem <= '0;
         sb_wb  <= '0;
      end else begin
         sb_ex  <= sb_id;
         sb_mem <= sb_ex;
         sb_wb  <= sb_mem;
      end
   end

   // WB never matches: the register file is written before the consumer reads it
   assert property (@(posedge clk) disable iff (rst) sb_wb.valid || (sb_wb == '0));

`ifdef HAZARD_FWD_EN
   logic [1:0] dec_a, dec_b;

   assign hazard = id_valid && sb_ex.is_load && (ex_rs1 || ex_rs2);

   always_comb begin
      dec_a = 2'b00;
      dec_b = 2'b00;
      if (ex_rs1)       dec_a = 2'b10;
      else if (mem_rs1) dec_a = 2'b01;
      if (ex_rs2)       dec_b = 2'b10;
      else if (mem_rs2) dec_b = 2'b01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
         fwd_d <= 2'b00;
      end else if (flush_ex) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
         fwd_d <= 2'b00;
      end else begin
         fwd_a <= dec_a;
         fwd_b <= dec_b;
         fwd_d <= dec_b;
      end
   end
`else
   assign hazard = id_valid && (ex_rs1 || ex_rs2 || mem_rs1 || mem_rs2);
   assign fwd_a  = 2'b00;
   assign fwd_b  = 2'b00;
   assign fwd_d  = 2'b00;
`endif

   always_comb begin
      stall_if = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      state_d  = ST_RUN;
      if (ex_redirect) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
         state_d  = ST_FLUSH;
      end else if (hazard) begin
         stall_if = 1'b1;
         flush_ex = 1'b1;
         state_d  = ST_STALL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == ST_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
         if (state_d == ST_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

   assign state = state_q;

endmodule
